// File: rtl/adaptimer_pkg.sv
// Shared constants for the adaptimer read port: register map, FSM encoding,
// response codes and snapshot counter width.
package adaptimer_pkg;

    // Register offsets, selected by ARADDR[3:2]
    localparam logic [1:0] REG_TIMER_LO   = 2'd0;
    localparam logic [1:0] REG_TIMER_HI   = 2'd1;
    localparam logic [1:0] REG_SNAP_COUNT = 2'd2;
    localparam logic [1:0] REG_STATUS     = 2'd3;

    // Read-channel FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int SNAP_CNT_W = 32;

endpackage

// File: rtl/adaptimer_read_port_if.sv
// AXI4-Lite read-channel bundle between a bus master and the adaptimer read port.
interface adaptimer_read_port_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [DATA_W-1:0] S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport master (
        output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/adaptimer_read_port_snapshot.sv
// Snapshot state for tear-free 64-bit timer reads: latched timer value,
// count of LO captures and the HI-pairing status flags.
module adaptimer_snapshot
    import adaptimer_pkg::*;
(
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [63:0]           adaptimer,
    input  logic                  cap_lo,
    input  logic                  rd_hi,
    input  logic                  rd_status,
    output logic [63:0]           snapshot,
    output logic [SNAP_CNT_W-1:0] snap_count,
    output logic                  hi_pending,
    output logic                  hi_orphan
);

    // The three strobes come from one AR handshake, so at most one is set per cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            snapshot   <= '0;
            snap_count <= '0;
            hi_pending <= 1'b0;
            hi_orphan  <= 1'b0;
        end else if (cap_lo) begin
            snapshot   <= adaptimer;
            snap_count <= snap_count + 1'b1;
            hi_pending <= 1'b1;
        end else if (rd_hi) begin
            // A HI read without a preceding LO read returns a stale half; flag it.
            if (hi_pending)
                hi_pending <= 1'b0;
            else
                hi_orphan <= 1'b1;
        end else if (rd_status) begin
            hi_orphan <= 1'b0;
        end
    end

endmodule

// File: rtl/adaptimer_read_port.sv
// AXI4-Lite read-channel slave exposing the 64-bit adaptive timer through a
// 32-bit bus. Reading TIMER_LO freezes all 64 bits so TIMER_HI cannot tear.
module adaptimer_read_port
    import adaptimer_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
)(
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [63:0]                adaptimer,
    adaptimer_read_port_if.slave       bus
);

    logic [0:0]            state;
    logic                  arready;
    logic                  rvalid;
    logic [31:0]           rdata;
    logic [31:0]           rdata_next;
    logic [1:0]            reg_sel;
    logic                  ar_hs;
    logic [63:0]           snapshot;
    logic [SNAP_CNT_W-1:0] snap_count;
    logic                  hi_pending;
    logic                  hi_orphan;
    logic                  unused_bits;

    assign reg_sel = bus.S_AXI_ARADDR[3:2];
    assign ar_hs   = (state == ST_IDLE) && arready && bus.S_AXI_ARVALID;

    // Byte-lane bits and the low snapshot half are never read back.
    assign unused_bits = ^{bus.S_AXI_ARADDR[1:0], snapshot[31:0]};

    adaptimer_snapshot u_snap (
        .clock      (clock),
        .resetn     (resetn),
        .adaptimer  (adaptimer),
        .cap_lo     (ar_hs && (reg_sel == REG_TIMER_LO)),
        .rd_hi      (ar_hs && (reg_sel == REG_TIMER_HI)),
        .rd_status  (ar_hs && (reg_sel == REG_STATUS)),
        .snapshot   (snapshot),
        .snap_count (snap_count),
        .hi_pending (hi_pending),
        .hi_orphan  (hi_orphan)
    );

    // Read-data select; all sources are the values before this cycle's update.
    always_comb begin
        rdata_next = '0;
        case (reg_sel)
            REG_TIMER_LO:   rdata_next = adaptimer[31:0];
            REG_TIMER_HI:   rdata_next = snapshot[63:32];
            REG_SNAP_COUNT: rdata_next = snap_count;
            REG_STATUS:     rdata_next = {30'b0, hi_orphan, hi_pending};
            default:        rdata_next = '0;
        endcase
    end

    // Single-outstanding read FSM; ARREADY is registered so it stays low during reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    arready <= 1'b1;
                    if (ar_hs) begin
                        state   <= ST_RESP;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rdata   <= rdata_next;
                    end
                end
                ST_RESP: begin
                    if (bus.S_AXI_RREADY) begin
                        state   <= ST_IDLE;
                        arready <= 1'b1;
                        rvalid  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    arready <= 1'b0;
                    rvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.S_AXI_ARREADY = arready;
    assign bus.S_AXI_RVALID  = rvalid;
    assign bus.S_AXI_RDATA   = rdata;
    assign bus.S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_adaptimer_read_port.sv
// Directed bench for adaptimer_read_port: a table of register reads with
// hand-computed results plus sequences for reset, backpressure, counter
// wrap and reset during a pending response.
module tb_adaptimer_read_port;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [63:0] adaptimer = '0;
    int          checks = 0;
    int          failures = 0;

    adaptimer_read_port_if #(.ADDR_W(4), .DATA_W(32)) axi ();

    adaptimer_read_port #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .adaptimer (adaptimer),
        .bus       (axi)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [3:0]  addr;
        logic [63:0] timer;
        int          stall;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One read transaction: drive AR at a negedge, wait for the handshake,
    // hold RREADY low for 'stall' cycles (optionally bumping the timer), then accept.
    task automatic do_read(input string name, input logic [3:0] addr, input int stall,
                           input bit bump, output logic [31:0] data);
        int n;
        logic [31:0] first;
        @(negedge clock);
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_ARVALID = 1'b1;
        axi.S_AXI_RREADY  = 1'b0;
        n = 0;
        while (!axi.S_AXI_ARREADY && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL %s arready_timeout: got 0 expected 1", name);
        end
        @(negedge clock);
        axi.S_AXI_ARVALID = 1'b0;
        check({name, " rvalid_latency"}, {31'b0, axi.S_AXI_RVALID}, 32'd1);
        first = axi.S_AXI_RDATA;
        check({name, " rresp"}, {30'b0, axi.S_AXI_RRESP}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            if (bump) adaptimer = adaptimer + 64'd1;
            @(negedge clock);
            check({name, " stall_rvalid"}, {31'b0, axi.S_AXI_RVALID}, 32'd1);
            check({name, " stall_arready"}, {31'b0, axi.S_AXI_ARREADY}, 32'd0);
            check({name, " stall_rdata"}, axi.S_AXI_RDATA, first);
        end
        axi.S_AXI_RREADY = 1'b1;
        @(negedge clock);
        axi.S_AXI_RREADY = 1'b0;
        check({name, " rvalid_drop"}, {31'b0, axi.S_AXI_RVALID}, 32'd0);
        check({name, " arready_back"}, {31'b0, axi.S_AXI_ARREADY}, 32'd1);
        data = first;
    endtask

    initial begin
        logic [31:0] d;

        axi.S_AXI_ARADDR  = 4'h0;
        axi.S_AXI_ARVALID = 1'b1;
        axi.S_AXI_RREADY  = 1'b0;

        // Reset held 3 cycles with ARVALID asserted
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("reset arready", {31'b0, axi.S_AXI_ARREADY}, 32'd0);
            check("reset rvalid", {31'b0, axi.S_AXI_RVALID}, 32'd0);
            check("reset rdata", axi.S_AXI_RDATA, 32'd0);
        end
        resetn = 1'b1;
        @(negedge clock);
        check("release arready", {31'b0, axi.S_AXI_ARREADY}, 32'd1);
        axi.S_AXI_ARVALID = 1'b0;

        // Read sequence from reset state; each expectation follows from the previous rows
        vecs.push_back('{"hi_orphan",     4'h4, 64'h0000_0000_0000_0000, 0, 32'h0000_0000});
        vecs.push_back('{"status_orphan", 4'hC, 64'h0,                   1, 32'h0000_0002});
        vecs.push_back('{"status_clear",  4'hC, 64'h0,                   0, 32'h0000_0000});
        vecs.push_back('{"count0",        4'h8, 64'h0,                   0, 32'h0000_0000});
        vecs.push_back('{"lo_tear",       4'h0, 64'h0000_0001_FFFF_FFFF, 0, 32'hFFFF_FFFF});
        vecs.push_back('{"hi_tear",       4'h4, 64'h0000_0002_0000_0000, 0, 32'h0000_0001});
        vecs.push_back('{"status_ok",     4'hC, 64'h0,                   0, 32'h0000_0000});
        vecs.push_back('{"count1",        4'h8, 64'h0,                   2, 32'h0000_0001});
        vecs.push_back('{"lo_a",          4'h0, 64'h1234_5678_9ABC_DEF0, 0, 32'h9ABC_DEF0});
        vecs.push_back('{"lo_b",          4'h0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 32'hCCCC_DDDD});
        vecs.push_back('{"status_pend",   4'hC, 64'h0,                   0, 32'h0000_0001});
        vecs.push_back('{"hi_b",          4'h4, 64'h0,                   0, 32'hAAAA_BBBB});
        vecs.push_back('{"hi_again",      4'h4, 64'h0,                   0, 32'hAAAA_BBBB});
        vecs.push_back('{"status_orph2",  4'hF, 64'h0,                   0, 32'h0000_0002});
        vecs.push_back('{"count3",        4'hA, 64'h0,                   0, 32'h0000_0003});
        vecs.push_back('{"hi_lowbits",    4'h7, 64'h0,                   0, 32'hAAAA_BBBB});
        vecs.push_back('{"status_orph3",  4'hE, 64'h0,                   0, 32'h0000_0002});

        foreach (vecs[i]) begin
            adaptimer = vecs[i].timer;
            do_read(vecs[i].name, vecs[i].addr, vecs[i].stall, 1'b0, d);
            check({vecs[i].name, " rdata"}, d, vecs[i].exp);
        end

        // Backpressure on a LO read while the timer keeps counting
        adaptimer = 64'h0000_0005_0000_0100;
        do_read("bp_lo", 4'h0, 5, 1'b1, d);
        check("bp_lo rdata", d, 32'h0000_0100);
        adaptimer = adaptimer + 64'd1;
        do_read("bp_hi", 4'h4, 0, 1'b0, d);
        check("bp_hi rdata", d, 32'h0000_0005);
        do_read("bp_count", 4'h8, 0, 1'b0, d);
        check("bp_count rdata", d, 32'h0000_0004);

        // Counter wrap: preload FFFF_FFFF, one LO read rolls it to zero
        @(negedge clock);
        force dut.u_snap.snap_count = 32'hFFFF_FFFF;
        @(negedge clock);
        release dut.u_snap.snap_count;
        do_read("wrap_pre", 4'h8, 0, 1'b0, d);
        check("wrap_pre rdata", d, 32'hFFFF_FFFF);
        adaptimer = 64'h0000_0009_0000_0042;
        do_read("wrap_lo", 4'h0, 0, 1'b0, d);
        check("wrap_lo rdata", d, 32'h0000_0042);
        do_read("wrap_count", 4'h8, 0, 1'b0, d);
        check("wrap_count rdata", d, 32'h0000_0000);

        // Reset while a LO response is pending
        @(negedge clock);
        axi.S_AXI_ARADDR  = 4'h0;
        axi.S_AXI_ARVALID = 1'b1;
        axi.S_AXI_RREADY  = 1'b0;
        check("midrst arready", {31'b0, axi.S_AXI_ARREADY}, 32'd1);
        @(negedge clock);
        axi.S_AXI_ARVALID = 1'b0;
        check("midrst rvalid_pre", {31'b0, axi.S_AXI_RVALID}, 32'd1);
        resetn = 1'b0;
        @(negedge clock);
        check("midrst rvalid_drop", {31'b0, axi.S_AXI_RVALID}, 32'd0);
        check("midrst arready_low", {31'b0, axi.S_AXI_ARREADY}, 32'd0);
        check("midrst rdata", axi.S_AXI_RDATA, 32'd0);
        resetn = 1'b1;
        do_read("midrst_status", 4'hC, 0, 1'b0, d);
        check("midrst_status rdata", d, 32'h0000_0000);
        do_read("midrst_count", 4'h8, 0, 1'b0, d);
        check("midrst_count rdata", d, 32'h0000_0000);
        do_read("midrst_hi", 4'h4, 0, 1'b0, d);
        check("midrst_hi rdata", d, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound in case the design stops responding
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
